// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control, jump/branch
// redirection and halt/restart. Optional retired-instruction counter under FETCH_INSTR_COUNT_EN.
module fetch_pc_unit #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Halt,
    input  logic            Stall,
    input  logic            Jump,
    input  logic            BranchEn,
    input  logic            Zero,
    input  logic [PC_W-1:0] Target,
`ifdef FETCH_INSTR_COUNT_EN
    output logic [15:0]     InstrCount,
`endif
    output logic [PC_W-1:0] ProgCtr,
    output logic            Done,
    output logic            Running
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q, done_d;
    logic            running_q, running_d;

    // State, PC and status registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
            running_q <= running_d;
        end
    end

    // Next-state and next-PC selection; Stall outranks Halt outranks Jump outranks Branch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                pc_d   = START_PC;
                done_d = 1'b0;
                if (Start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (Halt) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                    end else if (Jump) begin
                        pc_d = Target;
                    end else if (BranchEn && Zero) begin
                        pc_d = Target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
                done_d  = 1'b0;
            end
        endcase

        running_d = (state_d == RUN);
    end

    assign ProgCtr = pc_q;
    assign Done    = done_q;
    assign Running = running_q;

`ifdef FETCH_INSTR_COUNT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts unstalled RUN edges (halt edge included), saturating; cleared on (re)start
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RUN) begin
            if (!Stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (Start) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign InstrCount = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, sequencing, jump/branch priority,
// stall, halt/restart, PC wrap, self-loop.
module tb_fetch_pc_unit;

    localparam int unsigned PC_W = 10;

    logic            Clk;
    logic            Reset;
    logic            Start;
    logic            Halt;
    logic            Stall;
    logic            Jump;
    logic            BranchEn;
    logic            Zero;
    logic [PC_W-1:0] Target;
    logic [PC_W-1:0] ProgCtr;
    logic            Done;
    logic            Running;
`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0]     InstrCount;
`endif

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(.PC_W(PC_W), .START_ADDR(0)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Halt(Halt),
        .Stall(Stall),
        .Jump(Jump),
        .BranchEn(BranchEn),
        .Zero(Zero),
        .Target(Target),
`ifdef FETCH_INSTR_COUNT_EN
        .InstrCount(InstrCount),
`endif
        .ProgCtr(ProgCtr),
        .Done(Done),
        .Running(Running)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [PC_W-1:0] pc,
                             input logic done, input logic run);
        check({tag, ".pc"}, 32'(ProgCtr), 32'(pc));
        check({tag, ".done"}, 32'(Done), 32'(done));
        check({tag, ".running"}, 32'(Running), 32'(run));
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Start = 1'b0; Halt = 1'b0; Stall = 1'b0;
        Jump = 1'b0; BranchEn = 1'b0; Zero = 1'b0;
        Target = '0;
    endtask

    initial begin
        Reset = 1'b0;
        idle_inputs();
        #2;
        check_all("reset_initial", 10'h000, 1'b0, 1'b0);
        step();
        check_all("reset_held", 10'h000, 1'b0, 1'b0);
        Reset = 1'b1;

        // IDLE ignores control inputs
        Jump = 1'b1; Halt = 1'b1; Stall = 1'b1; Target = 10'h077;
        step();
        check_all("idle_ignores", 10'h000, 1'b0, 1'b0);
        idle_inputs();

        Start = 1'b1;
        step();
        check_all("start", 10'h000, 1'b0, 1'b1);
        Start = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", 32'(ProgCtr), 32'(i));
        end

        Jump = 1'b1; BranchEn = 1'b1; Zero = 1'b0; Target = 10'h120;
        step();
        check_all("jump_over_branch", 10'h120, 1'b0, 1'b1);

        BranchEn = 1'b0; Target = 10'h010;
        step();
        check("jump_010", 32'(ProgCtr), 32'h010);

        Jump = 1'b0; BranchEn = 1'b1; Zero = 1'b0; Target = 10'h200;
        step();
        check("branch_not_taken", 32'(ProgCtr), 32'h011);
        Zero = 1'b1;
        step();
        check("branch_taken", 32'(ProgCtr), 32'h200);
        idle_inputs();

        Jump = 1'b1; Target = 10'h033;
        step();
        check("jump_033", 32'(ProgCtr), 32'h033);

        Stall = 1'b1; Halt = 1'b1; Jump = 1'b1; Target = 10'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("stall_hold", 10'h033, 1'b0, 1'b1);
        end

        Stall = 1'b0;
        step();
        check_all("halt", 10'h033, 1'b1, 1'b0);

        // HALTED ignores stall/jump/branch
        Halt = 1'b0; Stall = 1'b1; Jump = 1'b1; BranchEn = 1'b1; Zero = 1'b1; Target = 10'h155;
        step();
        check_all("halted_hold", 10'h033, 1'b1, 1'b0);
        idle_inputs();

        Start = 1'b1;
        step();
        check_all("restart", 10'h000, 1'b0, 1'b1);

        // Start is a no-op while running
        step();
        check_all("start_in_run", 10'h001, 1'b0, 1'b1);
        Start = 1'b0;

        Jump = 1'b1; Target = 10'h3FF;
        step();
        check("jump_3ff", 32'(ProgCtr), 32'h3FF);
        Jump = 1'b0;
        step();
        check_all("wrap", 10'h000, 1'b0, 1'b1);

        Jump = 1'b1; Target = 10'h001;
        step();
        check("self_loop_a", 32'(ProgCtr), 32'h001);
        step();
        check("self_loop_b", 32'(ProgCtr), 32'h001);

        Target = 10'h05A;
        step();
        check("jump_05a", 32'(ProgCtr), 32'h05A);
        Jump = 1'b0;

        // Asynchronous reset between edges
        #2;
        Reset = 1'b0;
        #1;
        check_all("async_reset", 10'h000, 1'b0, 1'b0);
        step();
        check_all("async_reset_held", 10'h000, 1'b0, 1'b0);
        Reset = 1'b1;

        Start = 1'b1;
        step();
        check_all("post_reset_start", 10'h000, 1'b0, 1'b1);
        Start = 1'b0;
        step();
        check("post_reset_seq", 32'(ProgCtr), 32'h001);

`ifdef FETCH_INSTR_COUNT_EN
        check("count_after_2", 32'(InstrCount), 32'd1);
        for (int i = 0; i < 5; i++) step();
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        check("count_7", 32'(InstrCount), 32'd7);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("count_clear", 32'(InstrCount), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-sequencing stage that sits directly downstream of the control decoder.
- Consumes the decoder's Jump/BranchEn outputs, the ALU zero flag and a branch target.
- Produces the instruction address driven into the instruction ROM.
- Owns program start/halt sequencing and the Done indication to the testbench/top level.

Parameters:
- PC_W, 10, width of program counter and target bus (instruction ROM depth 2^PC_W).
- START_ADDR, 0, address loaded on reset and on every program (re)start.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  reset, asynchronous, active-low; asserted (0) forces reset state immediately.
- Start  input  1  level request to begin/restart program execution.
- Halt  input  1  decoded halt instruction at current ProgCtr.
- Stall  input  1  freeze request (multi-cycle memory op); holds PC and state.
- Jump  input  1  from control decoder: unconditional absolute jump.
- BranchEn  input  1  from control decoder: conditional branch.
- Zero  input  1  ALU zero flag for current instruction.
- Target  input  PC_W  absolute jump/branch destination (from target LUT).
- ProgCtr  output  PC_W  current instruction address to instruction ROM.
- Done  output  1  program halted; registered.
- Running  output  1  high while in RUN state; registered/decoded from state.

Behaviour:
- States: IDLE, RUN, HALTED; registered, 2-bit encoding.
- Reset asserted (Reset=0, asynchronous): ProgCtr=START_ADDR, state=IDLE, Done=0, Running=0. Holds while Reset=0 regardless of Clk. Applies mid-operation too: any state aborts to IDLE.
- IDLE:
  - ProgCtr held at START_ADDR.
  - Start=1 -> RUN next edge; ProgCtr stays START_ADDR, so the first instruction fetched is START_ADDR.
  - Jump/BranchEn/Halt/Stall ignored.
- RUN, evaluated each edge, priority highest first:
  1. Stall=1: hold ProgCtr and state. Halt/Jump/Branch ignored that cycle.
  2. Halt=1: -> HALTED; ProgCtr unchanged; Done=1 from next edge.
  3. Jump=1: ProgCtr<=Target regardless of Zero/BranchEn. The decoder asserts Jump and BranchEn together; Jump wins.
  4. BranchEn=1 & Zero=1: ProgCtr<=Target.
  5. BranchEn=1 & Zero=0: ProgCtr<=ProgCtr+1.
  6. Otherwise: ProgCtr<=ProgCtr+1.
  - Start ignored in RUN.
- Increment is modulo 2^PC_W: all-ones wraps to 0, no flag.
- Target==ProgCtr on a taken jump is legal: PC holds (self-loop).
- HALTED:
  - ProgCtr and Done=1 held.
  - Start=1 -> RUN next edge with ProgCtr<=START_ADDR and Done<=0.
  - Stall/Jump/Branch ignored.
- Latency: control inputs sampled at the edge ending the cycle; new ProgCtr is visible one cycle later. No combinational path from any input to ProgCtr/Done.
- Running=1 exactly when state==RUN.

Optional Feature:
- Macro: FETCH_INSTR_COUNT_EN.
- Defined:
  - Adds output InstrCount[15:0], reset to 0.
  - Increments on every RUN-state edge with Stall=0, including the halt edge.
  - Saturates at 16'hFFFF.
  - Cleared to 0 when Start moves HALTED->RUN or IDLE->RUN.
  - Held in IDLE/HALTED.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset=0 mid-RUN at ProgCtr=0x05A, no clock edge -> ProgCtr=0x000, Done=0, Running=0 immediately. Release Reset, Start=1 one cycle -> Running=1, first fetch address 0x000.
- RUN, 4 plain cycles from 0 -> ProgCtr 1,2,3,4. Then Jump=1, BranchEn=1, Zero=0, Target=0x120 -> ProgCtr=0x120 next cycle.
- At ProgCtr=0x010: BranchEn=1, Zero=0, Target=0x200 -> 0x011. Then BranchEn=1, Zero=1, Target=0x200 -> 0x200.
- Stall=1 for 3 cycles with Jump=1, Halt=1 at ProgCtr=0x033 -> ProgCtr stays 0x033 and state stays RUN. Stall=0 with Halt=1 -> Done=1 next cycle, ProgCtr=0x033.
- PC_W=10, ProgCtr=0x3FF, no branch -> ProgCtr=0x000, still RUN.
- HALTED, Start=1 -> Done=0, ProgCtr=0x000, Running=1 next cycle. With FETCH_INSTR_COUNT_EN: 7 unstalled RUN cycles ending in halt -> InstrCount=7; restart -> 0.
